// File: rtl/pdl_sequencer.sv
// Purpose : multi-channel pulse-delay sequencer; one shared timebase counter drives
//           OUT_NUM delayed pulses per trigger, using a snapshot of delay/width/enable.
// Latency : trigger capture (sync1) at edge k -> RUN at k+1 -> pulse i rises at k+d+2.
//           The pulse stays high for w cycles. done is a one-cycle strobe in the last RUN cycle.
// Backpr. : none. Trigger edges outside ARMED are dropped for timing and flag sticky overrun.
// Ports   : clk, reset (async active-low), enable (arm level), trigger (async input),
//           cfg_we/cfg_addr/cfg_sel/cfg_data (delay or width register write),
//           chan_en (mask, snapshotted at trigger), pulse_out (registered),
//           armed/busy (state decodes), done (end-of-shot strobe), overrun (sticky).
module pdl_sequencer #(
  parameter int N       = 32,
  parameter int OUT_NUM = 8,
  parameter int ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               trigger,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic               cfg_sel,
  input  logic [N-1:0]       cfg_data,
  input  logic [OUT_NUM-1:0] chan_en,
  output logic [OUT_NUM-1:0] pulse_out,
  output logic               armed,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // trigger synchroniser
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic trig_edge;

  // live configuration
  logic [N-1:0] delay_q [OUT_NUM];
  logic [N-1:0] delay_d [OUT_NUM];
  logic [N-1:0] width_q [OUT_NUM];
  logic [N-1:0] width_d [OUT_NUM];

  // per-shot snapshot
  logic [N-1:0]       shadow_delay_q [OUT_NUM];
  logic [N-1:0]       shadow_delay_d [OUT_NUM];
  logic [N-1:0]       shadow_width_q [OUT_NUM];
  logic [N-1:0]       shadow_width_d [OUT_NUM];
  logic [OUT_NUM-1:0] shadow_en_q, shadow_en_d;

  // One extra bit so delay+width never wraps and the counter can reach it.
  logic [N:0] cnt_q, cnt_d;
  logic [N:0] end_t_q, end_t_d;
  logic [N:0] live_end   [OUT_NUM];
  logic [N:0] shadow_end [OUT_NUM];
  logic [N:0] live_max;

  logic [OUT_NUM-1:0] pulse_q, pulse_d;
  logic               overrun_q, overrun_d;
  logic               last_cycle;

  assign sync1_d   = trigger;
  assign sync2_d   = sync1_q;
  assign trig_edge = sync1_q & ~sync2_q;

  // Config writes. Addresses at or beyond OUT_NUM match no channel and are dropped.
  always_comb begin
    for (int i = 0; i < OUT_NUM; i++) begin
      delay_d[i] = delay_q[i];
      width_d[i] = width_q[i];
      if (cfg_we && (cfg_addr == ADDR_W'(i))) begin
        if (cfg_sel) begin
          width_d[i] = cfg_data;
        end else begin
          delay_d[i] = cfg_data;
        end
      end
    end
  end

  // Per-channel end times from both the live and the snapshotted configuration.
  always_comb begin
    for (int i = 0; i < OUT_NUM; i++) begin
      live_end[i]   = {1'b0, delay_q[i]} + {1'b0, width_q[i]};
      shadow_end[i] = {1'b0, shadow_delay_q[i]} + {1'b0, shadow_width_q[i]};
    end
  end

  // Shot length is taken from the live config at the trigger and stored with the
  // snapshot, which keeps the wide max tree out of the per-cycle done compare.
  // Zero-width or masked channels do not extend the shot.
  always_comb begin
    live_max = '0;
    for (int i = 0; i < OUT_NUM; i++) begin
      if (chan_en[i] && (width_q[i] != '0) && (live_end[i] > live_max)) begin
        live_max = live_end[i];
      end
    end
  end

  assign last_cycle = (state_q == S_RUN) && (cnt_q == end_t_q);

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    end_t_d     = end_t_q;
    shadow_en_d = shadow_en_q;
    pulse_d     = '0;
    for (int i = 0; i < OUT_NUM; i++) begin
      shadow_delay_d[i] = shadow_delay_q[i];
      shadow_width_d[i] = shadow_width_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_ARMED;
        end
      end

      S_ARMED: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (trig_edge) begin
          // Snapshot uses registered config, so a write in this same cycle
          // belongs to the next shot.
          for (int i = 0; i < OUT_NUM; i++) begin
            shadow_delay_d[i] = delay_q[i];
            shadow_width_d[i] = width_q[i];
          end
          shadow_en_d = chan_en;
          end_t_d     = live_max;
          cnt_d       = '0;
          state_d     = S_RUN;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        // In the last cycle cnt equals every channel's end or more, so all
        // outputs fall on the same edge that leaves RUN.
        for (int i = 0; i < OUT_NUM; i++) begin
          pulse_d[i] = shadow_en_q[i]
                     && (cnt_q >= {1'b0, shadow_delay_q[i]})
                     && (cnt_q < shadow_end[i]);
        end
        if (last_cycle) begin
          state_d = enable ? S_ARMED : S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Edges that cannot start a shot are remembered while enabled. Dropping
  // enable is the software acknowledge.
  always_comb begin
    overrun_d = overrun_q;
    if (!enable) begin
      overrun_d = 1'b0;
    end else if (trig_edge && (state_q != S_ARMED)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      end_t_q     <= '0;
      shadow_en_q <= '0;
      pulse_q     <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < OUT_NUM; i++) begin
        delay_q[i]        <= '0;
        width_q[i]        <= '0;
        shadow_delay_q[i] <= '0;
        shadow_width_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      end_t_q     <= end_t_d;
      shadow_en_q <= shadow_en_d;
      pulse_q     <= pulse_d;
      overrun_q   <= overrun_d;
      for (int i = 0; i < OUT_NUM; i++) begin
        delay_q[i]        <= delay_d[i];
        width_q[i]        <= width_d[i];
        shadow_delay_q[i] <= shadow_delay_d[i];
        shadow_width_q[i] <= shadow_width_d[i];
      end
    end
  end

  assign pulse_out = pulse_q;
  assign armed     = (state_q == S_ARMED);
  assign busy      = (state_q == S_RUN);
  assign done      = last_cycle;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdl_sequencer.sv
// Directed bench for pdl_sequencer built with N=8, OUT_NUM=6, ADDR_W=3.
// Time reference: "j" is the number of clock edges after edge k, where sync1
// first captures trigger=1. Outputs are sampled 1 ns after each rising edge.
module tb_pdl_sequencer;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       trigger;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic       cfg_sel;
  logic [7:0] cfg_data;
  logic [5:0] chan_en;
  logic [5:0] pulse_out;
  logic       armed;
  logic       busy;
  logic       done;
  logic       overrun;

  int         checks;
  int         errors;
  logic [5:0] exp_p;

  pdl_sequencer #(.N(8), .OUT_NUM(6), .ADDR_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .trigger   (trigger),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .chan_en   (chan_en),
    .pulse_out (pulse_out),
    .armed     (armed),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input bit sel, input int data);
    cfg_we   = 1'b1;
    cfg_addr = addr[2:0];
    cfg_sel  = sel;
    cfg_data = data[7:0];
    tick;
    cfg_we   = 1'b0;
  endtask

  // Raises trigger just long enough for sync1 to capture it; returns after edge k.
  task automatic fire;
    trigger = 1'b1;
    tick;
    trigger = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b0; trigger = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_sel = 1'b0; cfg_data = '0; chan_en = '0;
    tick; tick;
    checks++; if (pulse_out !== 6'h00) begin errors++; $display("FAIL rst_pulse got %h want 00", pulse_out); end
    checks++; if ({armed, busy, done, overrun} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b want 0000", {armed, busy, done, overrun}); end
    enable = 1'b1;
    tick;
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL rst_hold_armed got %b want 0", armed); end
    reset = 1'b1;
    #1;
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL rst_release_armed got %b want 0", armed); end
    tick;
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL rst_arm got %b want 1", armed); end
    checks++; if ({busy, overrun} !== 2'b00) begin errors++; $display("FAIL rst_arm_flags got %b want 00", {busy, overrun}); end
  endtask

  task automatic test_single_shot;
    wr(0, 0, 0); wr(0, 1, 1); wr(3, 0, 4); wr(3, 1, 3);
    chan_en = 6'h09;
    tick; tick;
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL single_armed got %b want 1", armed); end
    fire;
    for (int j = 1; j <= 11; j++) begin
      tick;
      exp_p = '0;
      exp_p[0] = (j >= 2 && j < 3);
      exp_p[3] = (j >= 6 && j < 9);
      checks++; if (pulse_out !== exp_p) begin errors++; $display("FAIL single_pulse j=%0d got %h want %h", j, pulse_out, exp_p); end
      checks++; if (done !== (j == 8)) begin errors++; $display("FAIL single_done j=%0d got %b want %b", j, done, (j == 8)); end
      checks++; if (busy !== (j <= 8)) begin errors++; $display("FAIL single_busy j=%0d got %b want %b", j, busy, (j <= 8)); end
    end
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL single_rearm got %b want 1", armed); end
  endtask

  task automatic test_snapshot;
    chan_en = 6'h08;
    fire;
    for (int j = 1; j <= 11; j++) begin
      tick;
      exp_p = '0;
      exp_p[3] = (j >= 6 && j < 9);
      checks++; if (pulse_out !== exp_p) begin errors++; $display("FAIL snap_pulse j=%0d got %h want %h", j, pulse_out, exp_p); end
      checks++; if (done !== (j == 8)) begin errors++; $display("FAIL snap_done j=%0d got %b want %b", j, done, (j == 8)); end
      if (j == 2) begin
        cfg_we = 1'b1; cfg_addr = 3'd3; cfg_sel = 1'b0; cfg_data = 8'd100;
      end
      if (j == 3) cfg_we = 1'b0;
    end
    tick; tick;
    fire;
    for (int j = 1; j <= 106; j++) begin
      tick;
      exp_p = '0;
      exp_p[3] = (j >= 102 && j < 105);
      checks++; if (pulse_out !== exp_p) begin errors++; $display("FAIL snap2_pulse j=%0d got %h want %h", j, pulse_out, exp_p); end
      checks++; if (done !== (j == 104)) begin errors++; $display("FAIL snap2_done j=%0d got %b want %b", j, done, (j == 104)); end
    end
  endtask

  task automatic test_zero_disabled;
    wr(1, 0, 2); wr(1, 1, 0); wr(2, 0, 1); wr(2, 1, 5);
    chan_en = 6'h02;
    tick;
    fire;
    for (int j = 1; j <= 5; j++) begin
      tick;
      checks++; if (pulse_out !== 6'h00) begin errors++; $display("FAIL zero_pulse j=%0d got %h want 00", j, pulse_out); end
      checks++; if (done !== (j == 1)) begin errors++; $display("FAIL zero_done j=%0d got %b want %b", j, done, (j == 1)); end
      checks++; if (busy !== (j == 1)) begin errors++; $display("FAIL zero_busy j=%0d got %b want %b", j, busy, (j == 1)); end
      checks++; if (armed !== (j >= 2)) begin errors++; $display("FAIL zero_armed j=%0d got %b want %b", j, armed, (j >= 2)); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL zero_overrun j=%0d got %b want 0", j, overrun); end
    end
  endtask

  task automatic test_retrigger;
    wr(0, 0, 20); wr(0, 1, 20);
    chan_en = 6'h01;
    tick;
    fire;
    for (int j = 1; j <= 45; j++) begin
      tick;
      exp_p = '0;
      exp_p[0] = (j >= 22 && j < 42);
      checks++; if (pulse_out !== exp_p) begin errors++; $display("FAIL retrig_pulse j=%0d got %h want %h", j, pulse_out, exp_p); end
      checks++; if (done !== (j == 41)) begin errors++; $display("FAIL retrig_done j=%0d got %b want %b", j, done, (j == 41)); end
      checks++; if (overrun !== (j >= 12 && j <= 20)) begin errors++; $display("FAIL retrig_overrun j=%0d got %b want %b", j, overrun, (j >= 12 && j <= 20)); end
      checks++; if (armed !== 1'b0) begin errors++; $display("FAIL retrig_armed j=%0d got %b want 0", j, armed); end
      if (j == 10) trigger = 1'b1;
      if (j == 11) trigger = 1'b0;
      if (j == 20) enable = 1'b0;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL retrig_idle_busy got %b want 0", busy); end
    enable = 1'b1;
    tick;
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL retrig_rearm got %b want 1", armed); end
  endtask

  task automatic test_boundary;
    wr(4, 0, 255); wr(4, 1, 1);
    chan_en = 6'h10;
    tick;
    fire;
    for (int j = 1; j <= 260; j++) begin
      tick;
      exp_p = '0;
      exp_p[4] = (j == 257);
      checks++; if (pulse_out !== exp_p) begin errors++; $display("FAIL bound_pulse j=%0d got %h want %h", j, pulse_out, exp_p); end
      checks++; if (done !== (j == 257)) begin errors++; $display("FAIL bound_done j=%0d got %b want %b", j, done, (j == 257)); end
      checks++; if (busy !== (j <= 257)) begin errors++; $display("FAIL bound_busy j=%0d got %b want %b", j, busy, (j <= 257)); end
    end
  endtask

  task automatic test_bad_addr;
    wr(2, 0, 3); wr(2, 1, 2);
    wr(6, 0, 9); wr(6, 1, 7); wr(7, 0, 9); wr(7, 1, 7);
    chan_en = 6'h04;
    tick;
    fire;
    for (int j = 1; j <= 9; j++) begin
      tick;
      exp_p = '0;
      exp_p[2] = (j >= 5 && j < 7);
      checks++; if (pulse_out !== exp_p) begin errors++; $display("FAIL badaddr_pulse j=%0d got %h want %h", j, pulse_out, exp_p); end
      checks++; if (done !== (j == 6)) begin errors++; $display("FAIL badaddr_done j=%0d got %b want %b", j, done, (j == 6)); end
    end
  endtask

  task automatic test_reset_mid_pulse;
    wr(0, 0, 5); wr(0, 1, 10);
    chan_en = 6'h01;
    tick;
    fire;
    for (int j = 1; j <= 8; j++) tick;
    checks++; if (pulse_out !== 6'h01) begin errors++; $display("FAIL midrst_pre_pulse got %h want 01", pulse_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b want 1", busy); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (pulse_out !== 6'h00) begin errors++; $display("FAIL midrst_async_pulse got %h want 00", pulse_out); end
    checks++; if ({armed, busy, done, overrun} !== 4'b0000) begin errors++; $display("FAIL midrst_async_flags got %b want 0000", {armed, busy, done, overrun}); end
    tick;
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL midrst_hold_armed got %b want 0", armed); end
    reset = 1'b1;
    tick;
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL midrst_rearm got %b want 1", armed); end
    checks++; if (pulse_out !== 6'h00) begin errors++; $display("FAIL midrst_after_pulse got %h want 00", pulse_out); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_single_shot;
    test_snapshot;
    test_zero_disabled;
    test_retrigger;
    test_boundary;
    test_bad_addr;
    test_reset_mid_pulse;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
